// File: rtl/opb_trigger_regbank.sv
// OPB slave register bank: C_NUM_REGS bus-writable 32-bit words driven into user logic.
// Each word is a level register or a self-clearing trigger held for C_PULSE_LEN cycles.
//
// state | meaning
// IDLE  | waiting for an address hit (blocked for one cycle after an ack)
// ACK   | single acknowledge cycle; a pending write commits on the edge ending it
module opb_trigger_regbank #(
  parameter logic [31:0]           C_BASEADDR   = 32'h0106_0100,
  parameter logic [31:0]           C_HIGHADDR   = 32'h0106_01FF,
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32,
  parameter int                    C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = 1,
  parameter int                    C_PULSE_LEN  = 1,
  parameter string                 C_FAMILY     = "virtex5"
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
  output logic                          Sl_xferAck,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]      user_data_out,
  output logic [C_NUM_REGS-1:0]         user_trig_active
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  localparam logic [7:0] PULSE_LEN8 = 8'(C_PULSE_LEN);
  localparam string unused_family = C_FAMILY;

  state_t      state_q, state_d;
  logic        ack_prev_q;
  logic        xfer_ack;
  logic        hit;
  logic        addr_in_win;
  logic [31:0] addr_idx;
  logic [31:0] lat_idx;
  logic [31:0] lat_data;
  logic [0:3]  lat_be;
  logic        lat_rnw;
  logic [31:0] wr_mask;
  logic        wr_any;
  logic [31:0] rd_data;
  logic [31:0] regs [C_NUM_REGS];
  logic [7:0]  cnt  [C_NUM_REGS];
  logic        unused_inputs;

  assign unused_inputs = OPB_seqAddr;

  assign addr_in_win = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign addr_idx    = (OPB_ABus - C_BASEADDR) >> 2;
  assign hit         = OPB_select && addr_in_win && (state_q == ST_IDLE) && !ack_prev_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q    <= ST_IDLE;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_prev_q <= xfer_ack;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xfer_ack = (state_q == ST_ACK);
  end

  // Capture the request on the hit edge so select may drop during ACK.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      lat_idx  <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      lat_rnw  <= 1'b0;
    end else if (hit) begin
      lat_idx  <= addr_idx;
      lat_data <= OPB_DBus;
      lat_be   <= OPB_BE;
      lat_rnw  <= OPB_RNW;
    end
  end

  assign wr_mask = {{8{lat_be[0]}}, {8{lat_be[1]}}, {8{lat_be[2]}}, {8{lat_be[3]}}};
  assign wr_any  = xfer_ack && !lat_rnw && (|lat_be);

  // A write wins over the hold countdown, so a retrigger on the expiry edge reloads.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        regs[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (wr_any && (lat_idx == 32'(k))) begin
          regs[k] <= (regs[k] & ~wr_mask) | (lat_data & wr_mask);
          cnt[k]  <= C_PULSE_MASK[k] ? PULSE_LEN8 : 8'd0;
        end else if (cnt[k] != 8'd0) begin
          cnt[k] <= cnt[k] - 8'd1;
          if (cnt[k] == 8'd1) regs[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (xfer_ack && lat_rnw) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (lat_idx == 32'(k)) rd_data = regs[k];
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_user
    assign user_data_out[32*g +: 32] = regs[g];
    assign user_trig_active[g]       = (cnt[g] != 8'd0);
  end

  assign Sl_DBus    = rd_data;
  assign Sl_xferAck = xfer_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_trigger_regbank.sv
// Bench for opb_trigger_regbank: directed table, hand-timed trigger/reset sequences,
// and random bus traffic checked against a time-stamped register model.
module tb_opb_trigger_regbank;

  localparam logic [31:0] BASE  = 32'h0106_0100;
  localparam logic [31:0] HIGH  = 32'h0106_01FF;
  localparam int          NREG  = 4;
  localparam int          PLEN  = 3;
  localparam logic [3:0]  PMASK = 4'b1001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:31]  opb_abus = '0;
  logic [0:3]   opb_be = '0;
  logic [0:31]  opb_dbus = '0;
  logic         opb_rnw = 1'b0;
  logic         opb_select = 1'b0;
  logic         opb_seqaddr = 1'b0;
  logic [0:31]  sl_dbus;
  logic         sl_xferack, sl_errack, sl_retry, sl_toutsup;
  logic [127:0] user_data_out;
  logic [3:0]   user_trig_active;

  opb_trigger_regbank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(NREG), .C_PULSE_MASK(PMASK), .C_PULSE_LEN(PLEN), .C_FAMILY("virtex5")
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
    .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_select), .OPB_seqAddr(opb_seqaddr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_xferack), .Sl_errAck(sl_errack), .Sl_retry(sl_retry),
    .Sl_toutSup(sl_toutsup), .user_data_out(user_data_out), .user_trig_active(user_trig_active)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model: value written plus the edge it landed on; triggers read 0 once PLEN edges passed.
  logic [31:0] m_val    [NREG];
  int          m_commit [NREG];
  logic [3:0]  pmask_v = PMASK;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [31:0] model_val(int k, int c);
    if (pmask_v[k] && (c - m_commit[k]) >= PLEN) return 32'h0;
    return m_val[k];
  endfunction

  function automatic logic model_active(int k, int c);
    return pmask_v[k] && ((c - m_commit[k]) < PLEN);
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NREG; k++) begin
      m_val[k]    = 32'h0;
      m_commit[k] = -1000;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [127:0] eu;
    logic [3:0]   ea;
    int           c;
    c = cyc_cnt;
    for (int k = 0; k < NREG; k++) begin
      eu[32*k +: 32] = model_val(k, c);
      ea[k]          = model_active(k, c);
    end
    chk({name, " user_data"}, user_data_out, eu);
    chk({name, " trig_active"}, 128'(user_trig_active), 128'(ea));
  endtask

  // Called at a negedge; returns at the negedge inside the expected ACK cycle.
  task automatic do_op(input logic rnw_i, input logic [31:0] addr, input logic [3:0] be_i,
                       input logic [31:0] data, input logic exp_ack, output logic [31:0] rd);
    logic        in_range;
    int          idx;
    int          c;
    logic [31:0] mask, cur;
    opb_abus   = addr;
    opb_be     = be_i;
    opb_dbus   = data;
    opb_rnw    = rnw_i;
    opb_select = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c  = cyc_cnt;
    rd = sl_dbus;
    opb_select = 1'b0;
    chk("ack_latency", 128'(sl_xferack), 128'(exp_ack));
    chk_model("op");
    in_range = (addr >= BASE) && (addr <= HIGH) && (((addr - BASE) >> 2) < NREG);
    idx = in_range ? int'((addr - BASE) >> 2) : 0;
    if (exp_ack && rnw_i)
      chk("read_data", 128'(rd), 128'(in_range ? model_val(idx, c) : 32'h0));
    if (exp_ack && in_range && !rnw_i && be_i != 4'b0000) begin
      mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
      cur  = model_val(idx, c);
      m_val[idx] = (cur & ~mask) | (data & mask);
      if (pmask_v[idx]) m_commit[idx] = c + 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        prev_ack;
    int          n_ack;
    logic [31:0] addr;

    tbl[0]  = '{1'b0, BASE + 32'h04, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, BASE + 32'h04, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b0, BASE + 32'h08, 4'b1111, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b0, BASE + 32'h08, 4'b0101, 32'hAABBCCDD, 32'h0};
    tbl[4]  = '{1'b1, BASE + 32'h08, 4'b1111, 32'h0,        32'h11BB33DD};
    tbl[5]  = '{1'b1, BASE + 32'h3C, 4'b1111, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, BASE + 32'h3C, 4'b1111, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b1, BASE + 32'h04, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[8]  = '{1'b1, BASE + 32'h08, 4'b1111, 32'h0,        32'h11BB33DD};
    tbl[9]  = '{1'b0, BASE + 32'h04, 4'b0000, 32'h12345678, 32'h0};
    tbl[10] = '{1'b1, BASE + 32'h04, 4'b1111, 32'h0,        32'hDEADBEEF};

    reset_model();

    // Hits while held in reset must do nothing.
    opb_abus = BASE; opb_be = 4'b1111; opb_dbus = 32'hFFFFFFFF; opb_rnw = 1'b0; opb_select = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset ack", 128'(sl_xferack), 128'(0));
      chk("reset dbus", 128'(sl_dbus), 128'(0));
      chk("reset user", user_data_out, 128'(0));
      chk("reset active", 128'(user_trig_active), 128'(0));
    end
    opb_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].rnw, tbl[i].addr, tbl[i].be, tbl[i].data, 1'b1, rd);
      if (tbl[i].rnw) chk($sformatf("table[%0d] read", i), 128'(rd), 128'(tbl[i].exp_rd));
      repeat (2) @(negedge clk);
    end
    chk("reg1 stable", 128'(user_data_out[63:32]), 128'(32'hDEADBEEF));
    chk("reg2 merged", 128'(user_data_out[95:64]), 128'(32'h11BB33DD));

    // Trigger: visible for exactly PLEN cycles after the committing edge.
    do_op(1'b0, BASE, 4'b1111, 32'h1, 1'b1, rd);
    chk("trig pre-commit", 128'(user_data_out[31:0]), 128'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("trig data c%0d", i), 128'(user_data_out[31:0]), 128'(i < 3 ? 32'h1 : 32'h0));
      chk($sformatf("trig active c%0d", i), 128'(user_trig_active[0]), 128'(i < 3));
    end

    // Retrigger during the hold: new value, hold restarts from the second write.
    do_op(1'b0, BASE, 4'b1111, 32'h1, 1'b1, rd);
    @(negedge clk);
    chk("retrig first hold", 128'(user_data_out[31:0]), 128'(32'h1));
    @(negedge clk);
    do_op(1'b0, BASE, 4'b1111, 32'h5, 1'b1, rd);
    chk("retrig in ack", 128'(user_data_out[31:0]), 128'(32'h1));
    chk("retrig in ack active", 128'(user_trig_active[0]), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("retrig data c%0d", i), 128'(user_data_out[31:0]), 128'(i < 3 ? 32'h5 : 32'h0));
      chk($sformatf("retrig active c%0d", i), 128'(user_trig_active[0]), 128'(i < 3));
    end
    repeat (2) @(negedge clk);

    // Select held high: acks every third cycle, never adjacent.
    opb_abus = BASE + 32'h04; opb_rnw = 1'b1; opb_be = 4'b1111; opb_select = 1'b1;
    prev_ack = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sl_xferack) begin
        n_ack++;
        chk("held read data", 128'(sl_dbus), 128'(32'hDEADBEEF));
      end
      chk("held back-to-back", 128'(sl_xferack & prev_ack), 128'(0));
      prev_ack = sl_xferack;
    end
    opb_select = 1'b0;
    chk("held ack count", 128'(n_ack), 128'(4));
    repeat (2) @(negedge clk);

    // Reset mid-hold clears outputs without waiting for a clock.
    do_op(1'b0, BASE, 4'b1111, 32'hFF, 1'b1, rd);
    @(negedge clk);
    chk("mid-hold active", 128'(user_trig_active[0]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid-hold rst user", user_data_out, 128'(0));
    chk("mid-hold rst active", 128'(user_trig_active), 128'(0));
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-ACK: no ack, no commit, nothing after release.
    opb_abus = BASE + 32'h04; opb_rnw = 1'b0; opb_be = 4'b1111; opb_dbus = 32'h12345678;
    opb_select = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid-ack ack", 128'(sl_xferack), 128'(1));
    #2 rst_n = 1'b0;
    opb_select = 1'b0;
    #1;
    chk("mid-ack rst ack", 128'(sl_xferack), 128'(0));
    chk("mid-ack rst user", user_data_out, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-release ack", 128'(sl_xferack), 128'(0));
      chk("post-release user", user_data_out, 128'(0));
    end

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: addr = BASE + 32'(4 * $urandom_range(0, 3));
        6, 7:             addr = BASE + 32'(4 * $urandom_range(4, 63));
        8:                addr = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
        default:          addr = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 16))
                                                      : HIGH + 32'd1 + 32'(4 * $urandom_range(0, 16));
      endcase
      do_op(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom,
            (addr >= BASE) && (addr <= HIGH), rd);
      repeat (2 + $urandom_range(0, 3)) begin
        @(negedge clk);
        chk_model("idle");
        chk("idle ack", 128'(sl_xferack), 128'(0));
        chk("idle dbus", 128'(sl_dbus), 128'(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
